// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU control sequencer: takes one decoded instruction per handshake, steps it through
// decode/execute/memory/write-back, drives the ALU control code and memory/register strobes, and keeps the last ALU flags.
module alu_op_sequencer #(
  parameter logic [5:0] LWNOR_OP    = 6'h30,
  parameter logic [2:0] ILLEGAL_GIN = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zout,
  input  logic       nout,
  input  logic       vout,
  output logic [2:0] gin,
  output logic       alu_src_b,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       branch_taken,
  output logic [2:0] flags,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, EXEC2, WB} state_t;
  typedef enum logic [2:0] {CL_R, CL_LW, CL_SW, CL_BEQ, CL_LWNOR, CL_BAD} op_class_t;

  state_t     state, next_state;
  op_class_t  op_class;
  logic [5:0] op_q, funct_q;
  logic [2:0] r_gin;
  logic [2:0] flags_q;

  assign flags = flags_q;

  // Class and R-type ALU code come from the latched fields, so they stay stable for the whole instruction.
  always_comb begin
    op_class = CL_BAD;
    r_gin    = ILLEGAL_GIN;
    if (op_q == 6'h00) begin
      case (funct_q)
        6'h20: begin op_class = CL_R; r_gin = 3'b010; end
        6'h22: begin op_class = CL_R; r_gin = 3'b110; end
        6'h24: begin op_class = CL_R; r_gin = 3'b000; end
        6'h25: begin op_class = CL_R; r_gin = 3'b001; end
        6'h27: begin op_class = CL_R; r_gin = 3'b011; end
        6'h2a: begin op_class = CL_R; r_gin = 3'b111; end
        default: op_class = CL_BAD;
      endcase
    end else if (op_q == 6'h23) begin
      op_class = CL_LW;
    end else if (op_q == 6'h2b) begin
      op_class = CL_SW;
    end else if (op_q == 6'h04) begin
      op_class = CL_BEQ;
    end else if (op_q == LWNOR_OP) begin
      op_class = CL_LWNOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      funct_q <= '0;
      flags_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && instr_valid) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
      if (state == EXEC || state == EXEC2) begin
        flags_q <= {vout, nout, zout};
      end
    end
  end

  always_comb begin
    next_state   = state;
    instr_ready  = 1'b0;
    gin          = ILLEGAL_GIN;
    alu_src_b    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    branch_taken = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) next_state = DECODE;
      end
      DECODE: begin
        if (op_class == CL_BAD) begin
          err        = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        case (op_class)
          CL_R: begin
            gin        = r_gin;
            next_state = WB;
          end
          CL_LW, CL_SW, CL_LWNOR: begin
            gin        = 3'b010;
            alu_src_b  = 1'b1;
            next_state = MEM;
          end
          CL_BEQ: begin
            gin          = 3'b110;
            branch_taken = zout;
            done         = 1'b1;
            next_state   = IDLE;
          end
          default: next_state = IDLE;
        endcase
      end
      MEM: begin
        if (op_class == CL_SW) begin
          mem_write  = 1'b1;
          done       = 1'b1;
          next_state = IDLE;
        end else begin
          mem_read   = 1'b1;
          next_state = (op_class == CL_LWNOR) ? EXEC2 : WB;
        end
      end
      EXEC2: begin
        // Loaded word is still on the read port while the ALU NORs it with rt.
        gin        = 3'b011;
        alu_src_b  = 1'b1;
        mem_read   = 1'b1;
        next_state = WB;
      end
      WB: begin
        reg_write  = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle control FSM at the control end of the ALU interface.
- Accepts one decoded instruction (opcode/funct) per handshake and drives the 3-bit ALU control code `gin` across execute steps.
- Samples the ALU status flags (zout, nout, vout) into a flag register and resolves branches from them.
- Issues memory and write-back strobes for lw/sw/lwnor, so the datapath runs one instruction over several cycles.

Parameters:
- LWNOR_OP, 6'h30, opcode of lwnor (load word, then NOR the loaded word with rt).
- ILLEGAL_GIN, 3'b010, gin value driven when no ALU operation is active (ADD, harmless).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction fields valid
- instr_ready  output  1  FSM can accept an instruction (high only in IDLE)
- opcode  input  6  instruction[31:26]
- funct  input  6  instruction[5:0]
- zout  input  1  ALU zero flag
- nout  input  1  ALU negative flag
- vout  input  1  ALU overflow flag
- gin  output  3  ALU control: 010 add, 110 sub, 111 slt, 000 and, 001 or, 011 nor
- alu_src_b  output  1  1 = immediate/loaded operand on ALU B, 0 = rt
- mem_read  output  1  data memory read strobe
- mem_write  output  1  data memory write strobe
- reg_write  output  1  register file write strobe (one cycle)
- branch_taken  output  1  one-cycle pulse: beq condition met
- flags  output  3  registered {v,n,z} from last EXEC cycle
- done  output  1  one-cycle pulse, instruction retired
- err  output  1  one-cycle pulse, unsupported opcode/funct

Behaviour:
- States: IDLE, DECODE, EXEC, MEM, EXEC2, WB.
- Reset (synchronous, active-high; clk/reset as named above):
  - Forces IDLE; clears flags and the latched opcode/funct.
  - All strobes and pulses low; gin = ILLEGAL_GIN; instr_ready = 1 in the cycle after reset deasserts.
  - Reset mid-instruction abandons it: no done, no reg_write.
- Accept: in IDLE, instr_valid & instr_ready latches opcode/funct; next state is DECODE. instr_valid is ignored outside IDLE.
- DECODE:
  - Maps the latched fields to an op class:
    - R-type (opcode 0): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2a slt.
    - lw 0x23, sw 0x2b, beq 0x04, LWNOR_OP.
  - Anything else: err = 1 this cycle, return to IDLE, no done.
- EXEC:
  - gin per class: R-type from the funct map; lw/sw/lwnor 010 with alu_src_b = 1; beq 110.
  - flags <= {vout, nout, zout} at the end of EXEC, for every class.
  - beq: branch_taken = zout in this cycle; done = 1; next state IDLE.
  - R-type goes to WB; lw/sw/lwnor go to MEM.
- MEM:
  - lw/lwnor: mem_read = 1.
  - sw: mem_write = 1 and done = 1; next state IDLE.
  - lw goes to WB; lwnor goes to EXEC2.
- EXEC2 (lwnor only): gin = 011, alu_src_b = 1, mem_read = 1 (data held); flags updated from ALU; next state WB.
- WB: reg_write = 1, done = 1; next state IDLE.
- Outputs:
  - All outputs are combinational from state plus latched fields; gin = ILLEGAL_GIN in IDLE/DECODE/WB.
  - flags is the only registered output besides state.
- Latency, in cycles from the accept edge to the done cycle:
  - beq 2; sw 3; R-type 3; lw 4; lwnor 5.
  - instr_ready returns high the cycle after done.
- Simultaneous events:
  - reset wins over instr_valid.
  - err and done are never high together.
  - Two back-to-back instructions accepted with instr_valid held high incur exactly one IDLE cycle between them.

Test Plan:
- Reset with instr_valid = 1 → instr_ready = 1, gin = 010, flags = 000, no strobes; first accept only after reset low.
- R-type sub (opcode 0, funct 0x22) with ALU returning zout = 1 → EXEC gin = 110, WB reg_write = 1 and done at accept+3, flags = 001.
- beq (0x04): once with zout = 1 → branch_taken pulse at accept+2; once with zout = 0 → no pulse. Both retire at accept+2 with gin = 110.
- lwnor (0x30) → EXEC gin = 010, MEM mem_read, EXEC2 gin = 011 with nout = 1 → flags = 010, reg_write + done at accept+5.
- Unsupported opcode 0x3F → err pulse at accept+1, no done, instr_ready back high at accept+2.
- lw accepted, reset asserted in MEM → next cycle IDLE, no reg_write/done, flags = 000.
